// File: rtl/counter_checker.sv
// Sequence checker for a free-running 0..MAX_VAL counter: hunts for a start
// value, confirms LOCK_CNT consecutive increments, then flags any break in sequence.
module counter_checker #(
  parameter int MAX_VAL  = 15,
  parameter int LOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] count_in,
  input  logic       clr_err,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_count,
  output logic [3:0] expected,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] MAX4  = 4'(MAX_VAL);
  localparam logic [3:0] LOCK4 = 4'(LOCK_CNT);

  state_t     state;
  logic [3:0] match;
  logic       in_range;
  logic       hit;
  logic [3:0] nxt_in;

  // expected never exceeds MAX_VAL, so a hit implies count_in is in range.
  assign in_range  = (count_in <= MAX4);
  assign hit       = (count_in == expected);
  assign nxt_in    = (count_in == MAX4) ? 4'd0 : count_in + 4'd1;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      match     <= 4'd0;
      expected  <= 4'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      err <= 1'b0;
      if (en) begin
        case (state)
          HUNT: begin
            if (in_range) begin
              expected <= nxt_in;
              match    <= 4'd0;
              state    <= SYNC;
            end
          end
          SYNC: begin
            if (hit) begin
              expected <= nxt_in;
              match    <= match + 4'd1;
              if (match + 4'd1 == LOCK4) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match <= 4'd0;
              if (in_range) begin
                expected <= nxt_in;
                state    <= SYNC;
              end else begin
                state <= HUNT;
              end
            end
          end
          LOCKED: begin
            if (hit) begin
              expected <= nxt_in;
            end else begin
              err    <= 1'b1;
              locked <= 1'b0;
              match  <= 4'd0;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              if (in_range) begin
                expected <= nxt_in;
                state    <= SYNC;
              end else begin
                state <= HUNT;
              end
            end
          end
          default: begin
            state  <= HUNT;
            match  <= 4'd0;
            locked <= 1'b0;
          end
        endcase
      end
      // A coincident clear overrides the increment above.
      if (clr_err) err_count <= 8'd0;
    end
  end

endmodule
